// File: rtl/vm80a_wb_master_if.sv
// rtl/vm80a_wb_master_if.sv - Wishbone initiator bus bundle for the vm80a bridge
//
// Purpose: groups the Wishbone signals between vm80a_wb_master and a peripheral.
// Signals:
//   wb_adr_o  16  address            (master -> slave)
//   wb_dat_o   8  write data         (master -> slave)
//   wb_dat_i   8  read data          (slave  -> master)
//   wb_cyc_o   1  cycle              (master -> slave)
//   wb_stb_o   1  strobe             (master -> slave)
//   wb_we_o    1  write enable       (master -> slave)
//   wb_ack_i   1  acknowledge        (slave  -> master)
// Modports: master (bridge side), slave (peripheral side).

interface vm80a_wb_master_if;
   logic [15:0] wb_adr_o;
   logic [7:0]  wb_dat_o;
   logic [7:0]  wb_dat_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/vm80a_wb_master.sv
// rtl/vm80a_wb_master.sv - vm80a pin-level memory cycles to single Wishbone cycles
//
// Purpose: decodes CPU accesses inside an address window and turns each strobe
// assertion into exactly one Wishbone cycle, stalling the CPU via cpu_ready
// while the cycle is outstanding. Read data and the sync status byte are latched.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   cpu_a/cpu_dout          CPU address and data out (status byte during sync)
//   cpu_wr_n/cpu_dbin/sync  CPU write (low), read (high) and status strobes
//   cpu_din                 latched read data (FF after timeout or reset)
//   cpu_ready               CPU wait control, 0 = wait
//   cpu_sel                 strobe-qualified window hit, data mux select
//   stat_o                  status byte latched at sync
//   to_o                    one-cycle pulse on forced termination
//   wb                      Wishbone initiator (master modport)

module vm80a_wb_master #(
   parameter logic [7:0] WIN_BASE = 8'hFE,
   parameter logic [7:0] WIN_MASK = 8'hFF,
   parameter int         TIMEOUT  = 255
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [15:0]              cpu_a,
   input  logic [7:0]               cpu_dout,
   input  logic                     cpu_wr_n,
   input  logic                     cpu_dbin,
   input  logic                     cpu_sync,
   output logic [7:0]               cpu_din,
   output logic                     cpu_ready,
   output logic                     cpu_sel,
   output logic [7:0]               stat_o,
   output logic                     to_o,
   vm80a_wb_master_if.master        wb
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        cyc_q, cyc_nx;
   logic        stb_q, stb_nx;
   logic        we_q, we_nx;
   logic [15:0] adr_q, adr_nx;
   logic [7:0]  dat_q, dat_nx;
   logic [7:0]  din_q, din_nx;
   logic        to_q, to_nx;
   logic [7:0]  stat_q;
   logic        hit, req;

   // stat_o[0] flags an interrupt-acknowledge cycle, which must never reach the bus
   assign hit = ((cpu_a[15:8] & WIN_MASK) == (WIN_BASE & WIN_MASK)) && !stat_q[0];
   assign req = hit && (cpu_dbin || !cpu_wr_n);

   // Combinational so the wait is seen by the CPU in the same cycle the strobe appears
   assign cpu_ready = !((state == RD) || (state == WR) || ((state == IDLE) && req));
   assign cpu_sel   = req;
   assign cpu_din   = din_q;
   assign stat_o    = stat_q;
   assign to_o      = to_q;

   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = stb_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         cyc_q  <= 1'b0;
         stb_q  <= 1'b0;
         we_q   <= 1'b0;
         adr_q  <= 16'd0;
         dat_q  <= 8'd0;
         din_q  <= 8'hFF;
         to_q   <= 1'b0;
         stat_q <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cyc_q <= cyc_nx;
         stb_q <= stb_nx;
         we_q  <= we_nx;
         adr_q <= adr_nx;
         dat_q <= dat_nx;
         din_q <= din_nx;
         to_q  <= to_nx;
         if (cpu_sync)
            stat_q <= cpu_dout;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cyc_nx   = cyc_q;
      stb_nx   = stb_q;
      we_nx    = we_q;
      adr_nx   = adr_q;
      dat_nx   = dat_q;
      din_nx   = din_q;
      to_nx    = 1'b0;

      case (state)
         IDLE: begin
            // Write wins if the CPU ever drives both strobes at once
            if (req && !cpu_wr_n) begin
               state_nx = WR;
               cyc_nx   = 1'b1;
               stb_nx   = 1'b1;
               we_nx    = 1'b1;
               adr_nx   = cpu_a;
               dat_nx   = cpu_dout;
               cnt_nx   = 8'd0;
            end else if (req && cpu_dbin) begin
               state_nx = RD;
               cyc_nx   = 1'b1;
               stb_nx   = 1'b1;
               we_nx    = 1'b0;
               adr_nx   = cpu_a;
               cnt_nx   = 8'd0;
            end
         end

         RD, WR: begin
            if (wb.wb_ack_i) begin
               state_nx = DONE;
               cyc_nx   = 1'b0;
               stb_nx   = 1'b0;
               we_nx    = 1'b0;
               if (state == RD)
                  din_nx = wb.wb_dat_i;
            end else if (TO_EN && (cnt == TO_LAST)) begin
               state_nx = DONE;
               cyc_nx   = 1'b0;
               stb_nx   = 1'b0;
               we_nx    = 1'b0;
               to_nx    = 1'b1;
               if (state == RD)
                  din_nx = 8'hFF;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end

         DONE: begin
            // Wait for the strobe to drop so a long strobe cannot start a second cycle
            if (!cpu_dbin && cpu_wr_n)
               state_nx = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vm80a_wb_master.sv
// tb/tb_vm80a_wb_master.sv - self-checking bench for vm80a_wb_master

module tb_vm80a_wb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr_n;
   logic        cpu_dbin;
   logic        cpu_sync;
   logic [7:0]  cpu_din;
   logic        cpu_ready;
   logic        cpu_sel;
   logic [7:0]  stat_o;
   logic        to_o;

   always #5 clk = ~clk;

   vm80a_wb_master_if wb ();

   vm80a_wb_master #(
      .WIN_BASE (8'hFE),
      .WIN_MASK (8'hFF),
      .TIMEOUT  (16)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .cpu_a     (cpu_a),
      .cpu_dout  (cpu_dout),
      .cpu_wr_n  (cpu_wr_n),
      .cpu_dbin  (cpu_dbin),
      .cpu_sync  (cpu_sync),
      .cpu_din   (cpu_din),
      .cpu_ready (cpu_ready),
      .cpu_sel   (cpu_sel),
      .stat_o    (stat_o),
      .to_o      (to_o),
      .wb        (wb)
   );

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dat;
   } xact_t;

   xact_t exp_q[$];
   xact_t exp_x;
   int    n_checks   = 0;
   int    n_fail     = 0;
   int    n_stb_rise = 0;
   logic  stb_prev   = 1'b0;

   // Scoreboard: every acknowledged bus beat must match the next queued expectation
   always @(negedge clk) begin
      if (!rst && wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected adr=%h we=%b (no expected beat)", wb.wb_adr_o, wb.wb_we_o);
         end else begin
            exp_x = exp_q.pop_front();
            if (wb.wb_we_o !== exp_x.we || wb.wb_adr_o !== exp_x.adr ||
                (exp_x.we && wb.wb_dat_o !== exp_x.dat)) begin
               n_fail++;
               $display("FAIL sb_beat got we=%b adr=%h dat=%h exp we=%b adr=%h dat=%h",
                        wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o, exp_x.we, exp_x.adr, exp_x.dat);
            end
         end
      end
      if (wb.wb_stb_o && !stb_prev)
         n_stb_rise++;
      stb_prev <= wb.wb_stb_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++; if ({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o} !== 3'b000) begin n_fail++; $display("FAIL rst_cyc_stb_we got %b exp 000", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}); end
      n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", cpu_ready); end
      n_checks++; if (cpu_din !== 8'hFF) begin n_fail++; $display("FAIL rst_din got %h exp FF", cpu_din); end
      n_checks++; if (stat_o !== 8'h00) begin n_fail++; $display("FAIL rst_stat got %h exp 00", stat_o); end
      n_checks++; if (to_o !== 1'b0) begin n_fail++; $display("FAIL rst_to got %b exp 0", to_o); end
      n_checks++; if (wb.wb_adr_o !== 16'h0000 || wb.wb_dat_o !== 8'h00) begin n_fail++; $display("FAIL rst_adr_dat got %h/%h exp 0000/00", wb.wb_adr_o, wb.wb_dat_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read();
      cpu_a = 16'hFE01; cpu_dbin = 1'b1;
      #1;
      n_checks++; if (cpu_ready !== 1'b0 || wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_pre got ready=%b cyc=%b exp 0/0", cpu_ready, wb.wb_cyc_o); end
      tick();
      for (int k = 1; k <= 3; k++) begin
         n_checks++; if (wb.wb_stb_o !== 1'b1 || wb.wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rd_stb k=%0d got stb=%b cyc=%b exp 1/1", k, wb.wb_stb_o, wb.wb_cyc_o); end
         n_checks++; if (wb.wb_adr_o !== 16'hFE01 || wb.wb_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_adr_we k=%0d got %h/%b exp FE01/0", k, wb.wb_adr_o, wb.wb_we_o); end
         n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rd_wait k=%0d got %b exp 0", k, cpu_ready); end
         if (k == 3) begin
            exp_q.push_back('{1'b0, 16'hFE01, 8'h5A});
            wb.wb_ack_i = 1'b1; wb.wb_dat_i = 8'h5A;
         end
         tick();
      end
      wb.wb_ack_i = 1'b0; wb.wb_dat_i = 8'h00;
      n_checks++; if (wb.wb_stb_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_end got stb=%b cyc=%b exp 0/0", wb.wb_stb_o, wb.wb_cyc_o); end
      n_checks++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL rd_din got %h exp 5A", cpu_din); end
      n_checks++; if (cpu_ready !== 1'b1 || cpu_sel !== 1'b1) begin n_fail++; $display("FAIL rd_done got ready=%b sel=%b exp 1/1", cpu_ready, cpu_sel); end
      tick();
      n_checks++; if (wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rd_done_hold got cyc=%b exp 0", wb.wb_cyc_o); end
      cpu_dbin = 1'b0;
      tick();
   endtask

   task automatic test_write();
      cpu_a = 16'hFE00; cpu_dout = 8'h41; cpu_wr_n = 1'b0;
      #1;
      n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL wr_pre got ready=%b exp 0", cpu_ready); end
      exp_q.push_back('{1'b1, 16'hFE00, 8'h41});
      tick();
      wb.wb_ack_i = 1'b1;
      n_checks++; if (wb.wb_stb_o !== 1'b1 || wb.wb_we_o !== 1'b1 || wb.wb_dat_o !== 8'h41) begin n_fail++; $display("FAIL wr_stb got stb=%b we=%b dat=%h exp 1/1/41", wb.wb_stb_o, wb.wb_we_o, wb.wb_dat_o); end
      n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL wr_wait got %b exp 0", cpu_ready); end
      tick();
      wb.wb_ack_i = 1'b0;
      n_checks++; if (wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL wr_end got stb=%b we=%b ready=%b exp 0/0/1", wb.wb_stb_o, wb.wb_we_o, cpu_ready); end
      tick();
      n_checks++; if (wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr_done_hold got cyc=%b exp 0", wb.wb_cyc_o); end
      cpu_wr_n = 1'b1;
      tick();
      n_checks++; if (cpu_ready !== 1'b1 || wb.wb_adr_o !== 16'hFE00 || wb.wb_dat_o !== 8'h41) begin n_fail++; $display("FAIL wr_idle got ready=%b adr=%h dat=%h exp 1/FE00/41", cpu_ready, wb.wb_adr_o, wb.wb_dat_o); end
   endtask

   task automatic test_back_to_back();
      int rise0;
      rise0 = n_stb_rise;
      cpu_a = 16'hFE02; cpu_dbin = 1'b1;
      exp_q.push_back('{1'b0, 16'hFE02, 8'h77});
      tick();
      wb.wb_ack_i = 1'b1; wb.wb_dat_i = 8'h77;
      tick();
      wb.wb_ack_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (wb.wb_stb_o !== 1'b0 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_hold i=%0d got stb=%b ready=%b exp 0/1", i, wb.wb_stb_o, cpu_ready); end
         tick();
      end
      n_checks++; if (n_stb_rise - rise0 !== 1) begin n_fail++; $display("FAIL b2b_one_cycle got %0d cycles exp 1", n_stb_rise - rise0); end
      n_checks++; if (cpu_din !== 8'h77) begin n_fail++; $display("FAIL b2b_din1 got %h exp 77", cpu_din); end
      cpu_dbin = 1'b0;
      tick();
      cpu_a = 16'hFE03; cpu_dbin = 1'b1;
      exp_q.push_back('{1'b0, 16'hFE03, 8'h88});
      tick();
      wb.wb_ack_i = 1'b1; wb.wb_dat_i = 8'h88;
      tick();
      wb.wb_ack_i = 1'b0;
      n_checks++; if (n_stb_rise - rise0 !== 2) begin n_fail++; $display("FAIL b2b_two_cycles got %0d cycles exp 2", n_stb_rise - rise0); end
      n_checks++; if (cpu_din !== 8'h88) begin n_fail++; $display("FAIL b2b_din2 got %h exp 88", cpu_din); end
      cpu_dbin = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int to_cnt;
      to_cnt = 0;
      cpu_a = 16'hFE05; cpu_dbin = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (wb.wb_stb_o !== 1'b1 || to_o !== 1'b0) begin n_fail++; $display("FAIL to_wait i=%0d got stb=%b to=%b exp 1/0", i, wb.wb_stb_o, to_o); end
         tick();
      end
      n_checks++; if (wb.wb_stb_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL to_drop got stb=%b cyc=%b exp 0/0", wb.wb_stb_o, wb.wb_cyc_o); end
      n_checks++; if (cpu_din !== 8'hFF || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL to_din_ready got %h/%b exp FF/1", cpu_din, cpu_ready); end
      for (int i = 0; i < 4; i++) begin
         if (to_o === 1'b1) to_cnt++;
         tick();
      end
      n_checks++; if (to_cnt !== 1) begin n_fail++; $display("FAIL to_pulse got %0d cycles exp 1", to_cnt); end
      cpu_dbin = 1'b0;
      tick();
   endtask

   task automatic test_inta();
      cpu_a = 16'h1234; cpu_dbin = 1'b1;
      #1;
      n_checks++; if (cpu_ready !== 1'b1 || cpu_sel !== 1'b0) begin n_fail++; $display("FAIL miss_ready_sel got %b/%b exp 1/0", cpu_ready, cpu_sel); end
      tick();
      n_checks++; if (wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL miss_cyc got %b exp 0", wb.wb_cyc_o); end
      cpu_dbin = 1'b0;
      cpu_sync = 1'b1; cpu_dout = 8'h23;
      tick();
      cpu_sync = 1'b0;
      n_checks++; if (stat_o !== 8'h23) begin n_fail++; $display("FAIL inta_stat got %h exp 23", stat_o); end
      cpu_a = 16'hFE00; cpu_dbin = 1'b1;
      #1;
      n_checks++; if (cpu_ready !== 1'b1 || cpu_sel !== 1'b0) begin n_fail++; $display("FAIL inta_ready_sel got %b/%b exp 1/0", cpu_ready, cpu_sel); end
      repeat (2) tick();
      n_checks++; if (wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL inta_cyc got %b exp 0", wb.wb_cyc_o); end
      cpu_dbin = 1'b0;
      cpu_sync = 1'b1; cpu_dout = 8'hA2;
      tick();
      cpu_sync = 1'b0;
      n_checks++; if (stat_o !== 8'hA2) begin n_fail++; $display("FAIL sync_restore got %h exp A2", stat_o); end
   endtask

   task automatic test_reset_mid();
      cpu_a = 16'hFE10; cpu_dout = 8'h99; cpu_wr_n = 1'b0;
      tick();
      n_checks++; if (wb.wb_stb_o !== 1'b1 || wb.wb_we_o !== 1'b1) begin n_fail++; $display("FAIL rstm_start got stb=%b we=%b exp 1/1", wb.wb_stb_o, wb.wb_we_o); end
      rst = 1'b1; wb.wb_ack_i = 1'b1;
      tick();
      wb.wb_ack_i = 1'b0;
      n_checks++; if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_adr_o !== 16'h0000) begin n_fail++; $display("FAIL rstm_drop got cyc=%b stb=%b adr=%h exp 0/0/0000", wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o); end
      n_checks++; if (cpu_din !== 8'hFF || stat_o !== 8'h00) begin n_fail++; $display("FAIL rstm_regs got din=%h stat=%h exp FF/00", cpu_din, stat_o); end
      rst = 1'b0; cpu_wr_n = 1'b1;
      #1;
      n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rstm_idle_ready got %b exp 1", cpu_ready); end
      tick();
      n_checks++; if (wb.wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rstm_no_cycle got %b exp 0", wb.wb_cyc_o); end
   endtask

   initial begin
      rst = 1'b1;
      cpu_a = 16'h0000; cpu_dout = 8'h00;
      cpu_wr_n = 1'b1; cpu_dbin = 1'b0; cpu_sync = 1'b0;
      wb.wb_ack_i = 1'b0; wb.wb_dat_i = 8'h00;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_timeout();
      test_inta();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d beats exp 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vm80a_wb_master.md
Name: vm80a_wb_master

Overview:
Bus bridge that turns vm80a CPU pin-level memory cycles (address, wr_n, dbin, sync) into single Wishbone initiator cycles for peripherals such as uart_wb. It replaces ad-hoc strobe glue in board top levels. Accesses are decoded by an address window. While a Wishbone cycle is outstanding, the CPU is held through pin_ready. Read data and the CPU status byte are latched for the top-level data mux.

Parameters:
WIN_BASE, 8'hFE, value compared against cpu_a[15:8] for a window hit
WIN_MASK, 8'hFF, bit mask applied to both sides of the window compare
TIMEOUT, 255, wait cycles before forced termination (1..255); 0 disables the timeout

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_i  in  1  synchronous reset, active high
cpu_a  in  16  CPU address
cpu_dout  in  8  CPU data out (write data; status byte during sync)
cpu_wr_n  in  1  CPU write strobe, active low
cpu_dbin  in  1  CPU read strobe, active high
cpu_sync  in  1  CPU status strobe
cpu_din  out  8  latched read data
cpu_ready  out  1  to CPU pin_ready; 0 = wait
cpu_sel  out  1  window hit qualified by a strobe; top-level mux select for cpu_din
stat_o  out  8  status byte latched at sync
wb_adr_o  out  16  Wishbone address
wb_dat_o  out  8  Wishbone write data
wb_dat_i  in  8  Wishbone read data
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_ack_i  in  1  Wishbone acknowledge
to_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset values:
  - state IDLE; wb_cyc_o/wb_stb_o/wb_we_o = 0.
  - wb_adr_o = 0, wb_dat_o = 0.
  - cpu_din = 8'hFF, stat_o = 0, to_o = 0, timeout counter = 0.
- Reset mid-cycle: cyc/stb drop at that edge; any pending ack is discarded.
- stat_o: loaded from cpu_dout on every edge with cpu_sync = 1.
- hit = ((cpu_a[15:8] & WIN_MASK) == (WIN_BASE & WIN_MASK)) & ~stat_o[0]. INTA cycles never hit.
- req = hit & (cpu_dbin | ~cpu_wr_n).
- cpu_sel = hit & (cpu_dbin | ~cpu_wr_n).
- cpu_ready is combinational:
  - 0 in RD or WR.
  - 0 in IDLE while req = 1.
  - 1 otherwise.
  - This gives wait insertion with no cycle of slip.
- States:
  - IDLE, write: req & ~cpu_wr_n -> register cyc=stb=we=1, adr=cpu_a, dat_o=cpu_dout, counter=0 -> WR. Write has priority over dbin; both active together is illegal for the CPU but must be deterministic.
  - IDLE, read: req & cpu_dbin -> register cyc=stb=1, we=0, adr=cpu_a, counter=0 -> RD.
  - RD/WR on wb_ack_i = 1: clear cyc/stb/we; in RD also load cpu_din <= wb_dat_i; go DONE. Earliest ack is sampled the first cycle stb is high, so stb is high for at least 1 cycle.
  - RD/WR, no ack: counter increments. When counter == TIMEOUT-1 and TIMEOUT != 0: clear cyc/stb/we, cpu_din <= 8'hFF (read only), to_o = 1 for one cycle, go DONE.
  - DONE: cpu_ready = 1. Return to IDLE only when cpu_dbin = 0 and cpu_wr_n = 1. Strobes held longer never issue a second cycle.
- wb_ack_i in IDLE/DONE is ignored.
- wb_adr_o/wb_dat_o hold their values after a cycle until the next cycle starts.
- Non-hit accesses: no Wishbone activity and cpu_ready = 1.
- Exactly one Wishbone cycle per CPU strobe assertion.

Test Plan:
- Reset 3 cycles -> cyc/stb/we = 0, cpu_ready = 1, cpu_din = FF, stat_o = 00, to_o = 0.
- Read FE01: dbin = 1, slave acks on the 3rd stb cycle with 5A -> adr = FE01, we = 0, stb high exactly 3 cycles, cpu_ready low for those 3 cycles, cpu_din = 5A, state DONE.
- Write FE00 = 41: ack in the first stb cycle -> one-cycle stb with we = 1, dat_o = 41, cpu_ready low for 1 cycle, back to IDLE after wr_n rises.
- Read with dbin held 10 cycles after ack -> exactly one Wishbone cycle; a second read after dbin falls and rises again -> second cycle issued.
- TIMEOUT = 16, no ack on a read of FE05 -> stb drops after 16 cycles, to_o pulses once, cpu_din = FF, cpu_ready returns to 1.
- Access 1234, then a sync with status 23 (INTA bit set) followed by dbin on FE00 -> no cyc, cpu_ready = 1, cpu_sel = 0. Separately, assert wb_rst_i during a WR wait -> cyc/stb = 0 next edge, state IDLE.
